fixed_pair_aligner: RTL
=======================

Name: fixed_pair_aligner

Overview:
- Sits directly upstream of the fixed-point multiply-accumulate stage.
- Accepts two independent fixed-point operand streams (A and B), each with its own valid/ready/last, and buffers each in a small FIFO.
- Presents them downstream as strictly paired beats: A and B valid together, last together.
- Detects vectors of unequal length and re-aligns by flushing the remainder of the longer vector.

Parameters:
- WI1, 4, integer bits of operand A
- WF1, 8, fractional bits of operand A
- WI2, 3, integer bits of operand B
- WF2, 5, fractional bits of operand B
- DEPTH, 8, entries per channel FIFO; power of two, >= 2

Ports:
- clk  in  1  clock
- reset  in  1  synchronous, active-high reset
- s_A_data  in  WI1+WF1  signed operand A input
- s_A_valid  in  1  A input valid
- s_A_ready  out  1  A input ready
- s_A_last  in  1  last beat of A vector
- s_B_data  in  WI2+WF2  signed operand B input
- s_B_valid  in  1  B input valid
- s_B_ready  out  1  B input ready
- s_B_last  in  1  last beat of B vector
- A_data  out  WI1+WF1  paired A output
- A_valid  out  1  paired A valid
- A_ready  in  1  downstream A ready
- A_last  out  1  paired last
- B_data  out  WI2+WF2  paired B output
- B_valid  out  1  paired B valid
- B_ready  in  1  downstream B ready
- B_last  out  1  paired last (identical to A_last)
- mismatch  out  1  one-cycle pulse when a pair is popped with unequal last bits
- mismatch_sticky  out  1  set by mismatch, cleared only by reset
- A_count  out  $clog2(DEPTH)+1  A FIFO occupancy
- B_count  out  $clog2(DEPTH)+1  B FIFO occupancy

Behaviour:
- Reset (synchronous, active-high):
  - Both FIFOs empty, counts 0, state PAIR.
  - All valid outputs 0, mismatch and mismatch_sticky 0, s_*_ready 0 during the reset cycle.
  - Data outputs 0.
  - Reset mid-operation discards all buffered beats.
- FIFO entry: {last, data}.
  - Push when s_X_valid && s_X_ready.
  - s_X_ready = !full (registered-count based; no push when full).
  - Push and pop in the same cycle are both allowed when not full; count unchanged.
  - Pointers wrap modulo DEPTH.
- Latency:
  - Accepted beat is visible at the FIFO head the cycle after acceptance.
  - No same-cycle bypass when empty.
- Output pairing (state PAIR):
  - pair_valid = !A_empty && !B_empty.
  - A_valid = B_valid = pair_valid.
  - A_data/B_data = FIFO heads.
  - A_last = B_last = headA.last | headB.last.
  - Pop both FIFOs together when pair_valid && A_ready && B_ready.
  - If only one ready is high, nothing pops, and data/valid stay stable until both are ready (AXI-style hold).
- Mismatch handling:
  - On a pop where headA.last != headB.last: mismatch=1 for that cycle, mismatch_sticky<=1.
  - If A was not last, next state FLUSH_A; if B was not last, FLUSH_B.
- FLUSH_X:
  - Paired outputs valid=0.
  - Pop channel X's head every cycle it is non-empty; the discarded beat is never presented downstream.
  - On popping a beat with last=1, return to PAIR.
  - The other channel continues accepting inputs normally.
  - Reset in FLUSH returns to PAIR.
- States: PAIR, FLUSH_A, FLUSH_B.
  - PAIR -> FLUSH_A/FLUSH_B only on a mismatched pop.
  - FLUSH_X -> PAIR on a last-flagged pop of X.
- Counts: updated every cycle as count + push - pop; never exceed DEPTH.
- Arithmetic: no arithmetic on data; data passes bit-exact.

Test Plan:
- Equal vectors: A = {0x010,0x020,0x030}, B = {0x08,0x10,0x18}, last on 3rd beat, both readys high -> three paired beats, valid first appears 1 cycle after first accept, A_last=B_last=1 on beat 3 only, mismatch never set.
- Skewed arrival: A sends 4 beats back-to-back; B sends 4 beats starting 5 cycles later -> A_count reaches 4, no output valid until the first B beat is at the head, then 4 pairs in order.
- Backpressure: A_ready=1, B_ready=0 for 3 cycles with a pair pending -> outputs held stable, no pop, counts unchanged; both ready -> pop.
- Full FIFO: push 8 beats on A with B idle (DEPTH=8) -> A_count=8, s_A_ready=0, 9th beat not accepted; one pair pop -> s_A_ready=1 next cycle.
- Length mismatch: A = 5 beats, B = 3 beats -> 3 pairs with last on 3rd, mismatch pulse on that pop, sticky=1, A beats 4-5 flushed (never valid downstream), next vector pairs correctly.
- Reset mid-vector: 2 beats buffered on each channel, assert reset 1 cycle -> counts 0, valids 0, sticky 0; new vectors pair from the first beat.

Source files
------------

// File: rtl/fixed_pair_aligner.sv
`default_nettype none
// ============================================================================
// Module   : fixed_pair_aligner
// Brief    : Buffers two fixed-point operand streams and emits them as strictly
//            paired beats, flushing the tail of the longer vector on mismatch.
// Revision : 1.0 - initial release
// ============================================================================
module fixed_pair_aligner #(
    parameter int WI1   = 4,
    parameter int WF1   = 8,
    parameter int WI2   = 3,
    parameter int WF2   = 5,
    parameter int DEPTH = 8
) (
    input  logic                      clk,
    input  logic                      reset,
    input  logic signed [WI1+WF1-1:0] s_A_data,
    input  logic                      s_A_valid,
    output logic                      s_A_ready,
    input  logic                      s_A_last,
    input  logic signed [WI2+WF2-1:0] s_B_data,
    input  logic                      s_B_valid,
    output logic                      s_B_ready,
    input  logic                      s_B_last,
    output logic signed [WI1+WF1-1:0] A_data,
    output logic                      A_valid,
    input  logic                      A_ready,
    output logic                      A_last,
    output logic signed [WI2+WF2-1:0] B_data,
    output logic                      B_valid,
    input  logic                      B_ready,
    output logic                      B_last,
    output logic                      mismatch,
    output logic                      mismatch_sticky,
    output logic [$clog2(DEPTH):0]    A_count,
    output logic [$clog2(DEPTH):0]    B_count
);
    localparam int c_WA = WI1 + WF1;
    localparam int c_WB = WI2 + WF2;
    localparam int c_AW = $clog2(DEPTH);
    localparam int c_CW = c_AW + 1;
    localparam logic [c_CW-1:0] c_FULL = c_CW'(DEPTH);

    typedef enum logic [1:0] {
        S_PAIR    = 2'd0,
        S_FLUSH_A = 2'd1,
        S_FLUSH_B = 2'd2
    } state_t;

    state_t          r_state;
    logic            r_sticky;

    // Each FIFO entry is {last, data}
    logic [c_WA:0]   r_a_mem [DEPTH];
    logic [c_AW-1:0] r_a_wr;
    logic [c_AW-1:0] r_a_rd;
    logic [c_CW-1:0] r_a_count;
    logic [c_WB:0]   r_b_mem [DEPTH];
    logic [c_AW-1:0] r_b_wr;
    logic [c_AW-1:0] r_b_rd;
    logic [c_CW-1:0] r_b_count;

    logic            w_a_empty;
    logic            w_a_full;
    logic            w_a_push;
    logic            w_a_pop;
    logic [c_WA:0]   w_a_head;
    logic            w_b_empty;
    logic            w_b_full;
    logic            w_b_push;
    logic            w_b_pop;
    logic [c_WB:0]   w_b_head;
    logic            w_pair_valid;
    logic            w_pair_pop;
    logic            w_mismatch;
    logic            w_last;

    assign w_a_empty = (r_a_count == '0);
    assign w_a_full  = (r_a_count == c_FULL);
    assign w_a_head  = r_a_mem[r_a_rd];
    assign w_b_empty = (r_b_count == '0);
    assign w_b_full  = (r_b_count == c_FULL);
    assign w_b_head  = r_b_mem[r_b_rd];

    assign s_A_ready = !reset && !w_a_full;
    assign s_B_ready = !reset && !w_b_full;
    assign w_a_push  = s_A_valid && s_A_ready;
    assign w_b_push  = s_B_valid && s_B_ready;

    // Pairing is gated by reset so nothing is presented or popped in the reset cycle
    assign w_pair_valid = !reset && (r_state == S_PAIR) && !w_a_empty && !w_b_empty;
    assign w_pair_pop   = w_pair_valid && A_ready && B_ready;
    assign w_a_pop      = w_pair_pop || (!reset && (r_state == S_FLUSH_A) && !w_a_empty);
    assign w_b_pop      = w_pair_pop || (!reset && (r_state == S_FLUSH_B) && !w_b_empty);
    assign w_mismatch   = w_pair_pop && (w_a_head[c_WA] != w_b_head[c_WB]);
    assign w_last       = w_pair_valid && (w_a_head[c_WA] || w_b_head[c_WB]);

    assign A_valid         = w_pair_valid;
    assign B_valid         = w_pair_valid;
    assign A_data          = w_pair_valid ? w_a_head[c_WA-1:0] : '0;
    assign B_data          = w_pair_valid ? w_b_head[c_WB-1:0] : '0;
    assign A_last          = w_last;
    assign B_last          = w_last;
    assign mismatch        = w_mismatch;
    assign mismatch_sticky = r_sticky;
    assign A_count         = r_a_count;
    assign B_count         = r_b_count;

    always_ff @(posedge clk) begin
        if (w_a_push) begin
            r_a_mem[r_a_wr] <= {s_A_last, s_A_data};
        end
        if (w_b_push) begin
            r_b_mem[r_b_wr] <= {s_B_last, s_B_data};
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            r_a_wr    <= '0;
            r_a_rd    <= '0;
            r_a_count <= '0;
            r_b_wr    <= '0;
            r_b_rd    <= '0;
            r_b_count <= '0;
        end else begin
            if (w_a_push) begin
                r_a_wr <= r_a_wr + c_AW'(1);
            end
            if (w_a_pop) begin
                r_a_rd <= r_a_rd + c_AW'(1);
            end
            if (w_b_push) begin
                r_b_wr <= r_b_wr + c_AW'(1);
            end
            if (w_b_pop) begin
                r_b_rd <= r_b_rd + c_AW'(1);
            end
            r_a_count <= r_a_count + c_CW'(w_a_push) - c_CW'(w_a_pop);
            r_b_count <= r_b_count + c_CW'(w_b_push) - c_CW'(w_b_pop);
        end
    end

    // The channel whose head was not last still holds the rest of its vector
    always_ff @(posedge clk) begin
        if (reset) begin
            r_state  <= S_PAIR;
            r_sticky <= 1'b0;
        end else begin
            case (r_state)
                S_PAIR: begin
                    if (w_mismatch) begin
                        r_sticky <= 1'b1;
                        r_state  <= w_a_head[c_WA] ? S_FLUSH_B : S_FLUSH_A;
                    end
                end
                S_FLUSH_A: begin
                    if (w_a_pop && w_a_head[c_WA]) begin
                        r_state <= S_PAIR;
                    end
                end
                S_FLUSH_B: begin
                    if (w_b_pop && w_b_head[c_WB]) begin
                        r_state <= S_PAIR;
                    end
                end
                default: r_state <= S_PAIR;
            endcase
        end
    end

endmodule
`default_nettype wire
